// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the vector load/store unit.
package lsu_pkg;

    localparam int WIDTH_V = 256;
    localparam int BYTES   = WIDTH_V / 8;
    localparam int WADDR_W = 14;
    localparam int OFS_W   = $clog2(BYTES);
    localparam int ADDR_W  = WADDR_W + OFS_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR0  = 3'd4,
        ST_WR1  = 3'd5,
        ST_RESP = 3'd6
    } lsu_state_t;

endpackage

// File: rtl/lsu_byte_shifter.sv
// Combinational byte-lane shifter: splits store data/mask across the two
// words an unaligned access touches, and merges two read words into one
// unaligned load result.
module lsu_byte_shifter
    import lsu_pkg::*;
(
    input  logic [WIDTH_V-1:0] data,
    input  logic [BYTES-1:0]   mask,
    input  logic [OFS_W-1:0]   ofs,
    input  logic [WIDTH_V-1:0] lo_word,
    input  logic [WIDTH_V-1:0] hi_word,
    output logic [WIDTH_V-1:0] lo_data,
    output logic [WIDTH_V-1:0] hi_data,
    output logic [BYTES-1:0]   lo_be,
    output logic [BYTES-1:0]   hi_be,
    output logic [WIDTH_V-1:0] merged
);

    logic [8:0] lo_sh;
    logic [8:0] hi_sh;
    logic [5:0] hi_bsh;

    // Bit shift for the low beat and its complement for the high beat.
    assign lo_sh  = {1'b0, ofs, 3'b000};
    assign hi_sh  = 9'(WIDTH_V) - lo_sh;
    assign hi_bsh = 6'(BYTES) - {1'b0, ofs};

    // Offset zero never touches the second word, so the high beat is empty
    // and the load result is the single word read.
    always_comb begin
        lo_data = data << lo_sh;
        lo_be   = mask << ofs;
        hi_data = '0;
        hi_be   = '0;
        merged  = hi_word;
        if (ofs != '0) begin
            hi_data = data >> hi_sh;
            hi_be   = mask >> hi_bsh;
            merged  = (lo_word >> lo_sh) | (hi_word << hi_sh);
        end
    end

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store unit in front of dmem: splits word-crossing accesses
// into two beats, merges split load data and returns one response per
// request.
module vec_lsu
    import lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WIDTH_V-1:0]   req_wdata,
    input  logic [BYTES-1:0]     req_bmask,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WIDTH_V-1:0]   resp_rdata,
    output logic [WADDR_W-1:0]   mem_address,
    output logic [BYTES-1:0]     mem_byteena,
    output logic [WIDTH_V-1:0]   mem_data,
    output logic                 mem_rden,
    output logic                 mem_wren,
    input  logic [WIDTH_V-1:0]   mem_q
);

    lsu_state_t           state;
    logic [WADDR_W-1:0]   word_r;
    logic [OFS_W-1:0]     ofs_r;
    logic [WIDTH_V-1:0]   wdata_r;
    logic [BYTES-1:0]     bmask_r;
    logic [WIDTH_V-1:0]   lo_r;
    logic                 idle;
    logic [WADDR_W-1:0]   req_word;

    logic [WIDTH_V-1:0]   sh_data;
    logic [BYTES-1:0]     sh_mask;
    logic [OFS_W-1:0]     sh_ofs;
    logic [WIDTH_V-1:0]   lo_data;
    logic [WIDTH_V-1:0]   hi_data;
    logic [BYTES-1:0]     lo_be;
    logic [BYTES-1:0]     hi_be;
    logic [WIDTH_V-1:0]   merged;

    assign idle       = (state == ST_IDLE);
    assign req_ready  = idle;
    assign resp_valid = (state == ST_RESP);
    assign req_word   = req_addr[ADDR_W-1:OFS_W];

    // The shifter sees the live request while idle (first beat is issued on
    // the accept edge) and the latched request afterwards.
    assign sh_data = idle ? req_wdata : wdata_r;
    assign sh_mask = idle ? req_bmask : bmask_r;
    assign sh_ofs  = idle ? req_addr[OFS_W-1:0] : ofs_r;

    lsu_byte_shifter u_shifter (
        .data    (sh_data),
        .mask    (sh_mask),
        .ofs     (sh_ofs),
        .lo_word (lo_r),
        .hi_word (mem_q),
        .lo_data (lo_data),
        .hi_data (hi_data),
        .lo_be   (lo_be),
        .hi_be   (hi_be),
        .merged  (merged)
    );

    // Request payload and first read word; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (req_valid && idle) begin
            wdata_r <= req_wdata;
            bmask_r <= req_bmask;
        end
        if (state == ST_RD1) begin
            lo_r <= mem_q;
        end
    end

    // Sequencer: walks the beats of one request and drives registered dmem
    // controls; idle cycles return the bus to its quiet defaults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            word_r      <= '0;
            ofs_r       <= '0;
            resp_rdata  <= '0;
            mem_address <= '0;
            mem_byteena <= '1;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
        end else begin
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            mem_byteena <= '1;
            mem_data    <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        word_r <= req_word;
                        ofs_r  <= req_addr[OFS_W-1:0];
                        if (req_we) begin
                            resp_rdata <= '0;
                            if (lo_be != '0) begin
                                state       <= ST_WR0;
                                mem_wren    <= 1'b1;
                                mem_address <= req_word;
                                mem_byteena <= lo_be;
                                mem_data    <= lo_data;
                            end else if (hi_be != '0) begin
                                state       <= ST_WR1;
                                mem_wren    <= 1'b1;
                                mem_address <= req_word + 14'd1;
                                mem_byteena <= hi_be;
                                mem_data    <= hi_data;
                            end else begin
                                state <= ST_RESP;
                            end
                        end else begin
                            state       <= ST_RD0;
                            mem_rden    <= 1'b1;
                            mem_address <= req_word;
                        end
                    end
                end
                ST_RD0: begin
                    if (ofs_r != '0) begin
                        state       <= ST_RD1;
                        mem_rden    <= 1'b1;
                        mem_address <= word_r + 14'd1;
                    end else begin
                        state <= ST_CAP;
                    end
                end
                ST_RD1: state <= ST_CAP;
                ST_CAP: begin
                    resp_rdata <= merged;
                    state      <= ST_RESP;
                end
                ST_WR0: begin
                    if (hi_be != '0) begin
                        state       <= ST_WR1;
                        mem_wren    <= 1'b1;
                        mem_address <= word_r + 14'd1;
                        mem_byteena <= hi_be;
                        mem_data    <= hi_data;
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_WR1: state <= ST_RESP;
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_lsu.sv
// Bench for vec_lsu: byte-level reference memory, dmem model, beat and
// response scoreboards fed by the stimulus process.
module tb_vec_lsu;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [18:0]   req_addr;
    logic [255:0]  req_wdata;
    logic [31:0]   req_bmask;
    logic          resp_valid;
    logic          resp_ready;
    logic [255:0]  resp_rdata;
    logic [13:0]   mem_address;
    logic [31:0]   mem_byteena;
    logic [255:0]  mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [255:0]  mem_q;

    typedef struct {
        bit           we;
        logic [13:0]  addr;
        logic [31:0]  be;
        logic [255:0] data;
        int           cyc;
    } beat_t;

    typedef struct {
        logic [255:0] rdata;
        int           cyc;
    } resp_t;

    beat_t        bq[$];
    resp_t        rq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           stall_n = 0;
    logic [255:0] last_rdata = '0;
    logic [255:0] dmem [16384];
    logic [7:0]   refm [524288];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    vec_lsu dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_bmask   (req_bmask),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .mem_address (mem_address),
        .mem_byteena (mem_byteena),
        .mem_data    (mem_data),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    // dmem: byte-enabled write, one-cycle registered read
    always @(posedge clk) begin
        if (mem_wren)
            for (int k = 0; k < 32; k++)
                if (mem_byteena[k]) dmem[mem_address][8*k +: 8] <= mem_data[8*k +: 8];
        if (mem_rden) mem_q <= dmem[mem_address];
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] be_bits(input logic [31:0] be);
        logic [255:0] m;
        for (int k = 0; k < 32; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    // Beat monitor: every dmem access must be the next expected beat
    always @(negedge clk) begin
        beat_t b;
        if (!reset) begin
            if (mem_rden || mem_wren) begin
                chk("rden_wren_exclusive", 256'(mem_rden & mem_wren), 256'(0));
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual addr=%h be=%h required none", mem_address, mem_byteena);
                end else begin
                    b = bq.pop_front();
                    chk("beat_kind", 256'(mem_wren), 256'(b.we));
                    chk("beat_addr", 256'(mem_address), 256'(b.addr));
                    chk("beat_byteena", 256'(mem_byteena), 256'(b.be));
                    chk("beat_cycle", 256'(cyc), 256'(b.cyc));
                    if (b.we) chk("beat_data", mem_data & be_bits(mem_byteena), b.data);
                end
            end else begin
                chk("quiet_byteena", 256'(mem_byteena), 256'(32'hFFFF_FFFF));
                chk("quiet_data", mem_data, 256'(0));
            end
        end
    end

    // Response monitor: latency, stability under backpressure, data
    always @(negedge clk) begin
        static bit           active = 1'b0;
        static int           stalled = 0;
        static logic [255:0] held = '0;
        resp_t r;
        if (reset) begin
            active     = 1'b0;
            stalled    = 0;
            resp_ready = 1'b0;
        end else if (resp_valid) begin
            if (!active) begin
                active = 1'b1;
                held   = resp_rdata;
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=%h required none", resp_rdata);
                end else begin
                    chk("resp_latency", 256'(cyc), 256'(rq[0].cyc));
                end
            end else begin
                chk("resp_stable", resp_rdata, held);
                chk("req_ready_in_resp", 256'(req_ready), 256'(0));
            end
            if (stalled < stall_n) begin
                stalled++;
                resp_ready = 1'b0;
            end else begin
                resp_ready = ($urandom_range(0, 3) != 0);
            end
            if (resp_ready) begin
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                end
                last_rdata = resp_rdata;
                active     = 1'b0;
                stalled    = 0;
            end
        end else begin
            active     = 1'b0;
            resp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_req(input bit we, input logic [18:0] addr,
                          input logic [255:0] wd, input logic [31:0] bm);
        int           t;
        int           guard;
        int           nb;
        int           o;
        int           p;
        logic [13:0]  w;
        logic [31:0]  be;
        logic [255:0] d;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_bmask = bm;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 256'(req_ready), 256'(1));
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc;
        w = addr[18:5];
        o = int'(addr[4:0]);
        if (we) begin
            for (int k = 0; k < 32; k++)
                if (bm[k]) refm[(int'(addr) + k) % 524288] = wd[8*k +: 8];
            nb = 0;
            for (int j = 0; j < 2; j++) begin
                be = '0;
                d  = '0;
                for (int k = 0; k < 32; k++) begin
                    if (bm[k] && ((o + k < 32) == (j == 0))) begin
                        p = (o + k) % 32;
                        be[p] = 1'b1;
                        d[8*p +: 8] = wd[8*k +: 8];
                    end
                end
                if (be != '0) begin
                    bq.push_back('{1'b1, 14'(int'(w) + j), be, d, t + nb});
                    nb++;
                end
            end
            rq.push_back('{256'(0), t + nb});
        end else begin
            bq.push_back('{1'b0, w, 32'hFFFF_FFFF, 256'(0), t});
            if (o != 0) bq.push_back('{1'b0, 14'(int'(w) + 1), 32'hFFFF_FFFF, 256'(0), t + 1});
            for (int k = 0; k < 32; k++) d[8*k +: 8] = refm[(int'(addr) + k) % 524288];
            rq.push_back('{d, t + ((o == 0) ? 2 : 3)});
        end
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (rq.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("resp_timeout", 256'(rq.size()), 256'(0));
        rq.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] wd;
        logic [31:0]  bm;
        logic [18:0]  a;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_bmask = '0;
        for (int i = 0; i < 16384; i++) dmem[i] = '0;
        for (int i = 0; i < 524288; i++) refm[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_resp_valid", 256'(resp_valid), 256'(0));
        chk("rst_resp_rdata", resp_rdata, 256'(0));
        chk("rst_mem_rden", 256'(mem_rden), 256'(0));
        chk("rst_mem_wren", 256'(mem_wren), 256'(0));
        chk("rst_mem_address", 256'(mem_address), 256'(0));
        chk("rst_mem_byteena", 256'(mem_byteena), 256'(32'hFFFF_FFFF));
        chk("rst_mem_data", mem_data, 256'(0));
        reset = 1'b0;
        @(negedge clk);

        do_req(1'b1, 19'h00000, {32{8'hCC}}, 32'hFFFF_FFFF);
        do_req(1'b0, 19'h00000, '0, '0);
        chk("aligned_load", last_rdata, {32{8'hCC}});

        do_req(1'b1, 19'h000A4, {32{8'h55}}, 32'hFFFF_FFFF);
        do_req(1'b0, 19'h000A4, '0, '0);
        chk("unaligned_load", last_rdata, {32{8'h55}});

        do_req(1'b1, 19'h00108, {224'h0, 32'hBACADECA}, 32'h0000_000F);
        do_req(1'b0, 19'h00100, '0, '0);
        chk("partial_store_word", 256'(last_rdata[95:64]), 256'(32'hBACADECA));
        chk("partial_store_below", 256'(last_rdata[63:0]), 256'(0));

        do_req(1'b1, 19'h7FFF0, {32{8'hA5}}, 32'hFFFF_FFFF);
        do_req(1'b0, 19'h7FFF0, '0, '0);
        chk("wrap_load", last_rdata, {32{8'hA5}});

        stall_n = 3;
        do_req(1'b0, 19'h000A4, '0, '0);
        chk("stalled_load", last_rdata, {32{8'h55}});
        stall_n = 0;

        // Abort a split load while its second read beat is on the bus
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 19'h000A4;
        chk("abort_ready", 256'(req_ready), 256'(1));
        @(posedge clk);
        #1;
        bq.push_back('{1'b0, 14'd5, 32'hFFFF_FFFF, 256'(0), cyc});
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rd1_rden", 256'(mem_rden), 256'(1));
        chk("abort_rd1_addr", 256'(mem_address), 256'(6));
        reset = 1'b1;
        #1;
        chk("abort_rden_low", 256'(mem_rden), 256'(0));
        chk("abort_resp_valid", 256'(resp_valid), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        bq.delete();
        rq.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_resp_valid", 256'(resp_valid), 256'(0));
            chk("post_abort_req_ready", 256'(req_ready), 256'(1));
        end

        for (int n = 0; n < 250; n++) begin
            for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom();
            case ($urandom_range(0, 3))
                0: bm = 32'hFFFF_FFFF;
                1: bm = 32'h0;
                2: bm = $urandom();
                default: bm = 32'h1 << $urandom_range(0, 31);
            endcase
            a[18:5] = 14'(($urandom_range(0, 9) + 16381) % 16384);
            a[4:0]  = 5'($urandom_range(0, 31));
            stall_n = ($urandom_range(0, 7) == 0) ? 2 : 0;
            do_req(1'($urandom_range(0, 1)), a, wd, bm);
        end
        stall_n = 0;

        repeat (3) @(negedge clk);
        chk("beat_queue_empty", 256'(bq.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_lsu.md
Name: vec_lsu

Overview:
Vector load/store unit sitting directly upstream of the dmem data memory (256-bit words, 14-bit word address, 32-bit byte enable, 1-cycle synchronous read). It accepts byte-addressed 256-bit vector load/store requests from the pipeline MEM stage and splits any access that crosses a word boundary into two memory beats. For those split accesses it merges read data and generates per-beat byte enables. It returns one response per request through a valid/ready handshake.

Parameters:
WIDTH_V, 256, vector/memory word width in bits
BYTES, WIDTH_V/8 (32), bytes per word; byte-enable width
WADDR_W, 14, memory word-address width
OFS_W, $clog2(BYTES) (5), byte-offset width; request address width = WADDR_W+OFS_W (19)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  19  byte address; [18:5] = word W, [4:0] = offset o
req_wdata  in  256  store data, byte k at bits [8k+7:8k], goes to address A+k
req_bmask  in  32  store byte mask, bit k = request byte k; ignored for loads
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  256  load data (byte k = mem[A+k]); 0 for stores
mem_address  out  14  to dmem address
mem_byteena  out  32  to dmem byteena
mem_data  out  256  to dmem data
mem_rden  out  1  to dmem rden
mem_wren  out  1  to dmem wren
mem_q  in  256  from dmem q; valid one cycle after the cycle mem_rden was high

Behaviour:
- Reset (async): state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, mem_rden=0, mem_wren=0, mem_address=0, mem_byteena=all ones, mem_data=0. All mem_* outputs are registered.
- States: IDLE, RD0, RD1, CAP, WR0, WR1, RESP.
- Accept: req_valid&&req_ready at edge T latches the request. Its lower part is byte lanes with o+k<32 in word W. Its upper part is the remaining lanes in word W+1 (mod 2^14; word 16383 wraps to 0).
- Load: RD0 at T+1 (rden=1, addr W, byteena all ones).
  - If o==0: CAP at T+2, then resp at T+3.
  - If o!=0: RD1 at T+2 (rden=1, addr W+1, mem_q latched as lo), CAP at T+3, resp at T+4.
  - CAP: rdata = (lo >> 8o) | (mem_q << 8(32-o)), truncated to 256; aligned case uses mem_q directly.
- Store: beat masks are lo_be = (bmask << o)[31:0] and hi_be = bmask >> (32-o) (0 if o==0).
  - Beat data are wdata << 8o and wdata >> 8(32-o).
  - WR0 is issued iff lo_be!=0: wren=1, addr W, byteena lo_be.
  - WR1 is issued iff hi_be!=0: wren=1, addr W+1, byteena hi_be.
  - Skipped beats take no cycle. An all-zero mask goes straight to RESP at T+1.
- RESP: resp_valid=1 and resp_rdata stable until resp_valid&&resp_ready, then IDLE. req_ready rises the cycle after the handshake. Back-to-back requests are therefore not pipelined.
- Outside RD*/WR*: rden=wren=0, byteena all ones, data 0. rden and wren are never both 1.
- Reset mid-operation: abort immediately, no response. Beats already written remain committed.

Decomposition:
- Package lsu_pkg: WIDTH_V, BYTES, WADDR_W, OFS_W constants; lsu_state_t enum.
- One combinational sub-module, lsu_byte_shifter. It takes data/mask and offset and produces lo/hi beat data, lo/hi byte enables, and the load merge. It is shared by the store and load paths.

Test Plan:
(Bench instantiates dmem as the memory.)
1. Aligned store: addr 0x00000, wdata all 0xCC, mask 0xFFFFFFFF -> single WR beat at T+1 (addr 0, byteena FFFFFFFF), resp at T+2. Then aligned load at 0x00000 -> rden at T+1, resp_rdata all 0xCC at T+3.
2. Unaligned store: addr 0x000A4 (W=5, o=4), all 0x55, full mask -> WR0 addr 5 byteena FFFFFFF0, then WR1 addr 6 byteena 0000000F, resp at T+3.
3. Unaligned load: addr 0x000A4 after scenario 2 -> rden to addr 5 then addr 6, resp_rdata all 0x55 at T+4.
4. Partial store: addr 0x00108 (W=8, o=8), mask 0x0000000F, wdata[31:0]=0xBACADECA -> one beat, addr 8, byteena 00000F00, data[95:64]=BACADECA. Load 0x00100 returns BACADECA at [95:64] and other bytes unchanged.
5. Wrap: store at 0x7FFF0 (W=16383, o=16), full mask -> WR0 addr 16383 byteena FFFF0000, WR1 addr 0 byteena 0000FFFF.
6. Backpressure and abort:
   - Hold resp_ready=0 for 3 cycles -> resp_valid/resp_rdata stable, req_ready=0.
   - Assert reset during RD1 -> mem_rden=0 immediately, no resp_valid, req_ready=1 after release.
